// File: rtl/msk_and_hpc2_pipe.sv
// msk_and_hpc2_pipe: W-lane, d-share masked AND (HPC2 gadget) with a
// 2-stage valid/ready pipeline and a randomness handshake.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (ina, inb)
//   ina, inb [d*W]        sharings; lane k share i at bit k*d+i
//   rnd_valid / rnd_ready randomness handshake (consumed with the operands)
//   rnd [W*R]             lane k uses rnd[k*R +: R], R = d*(d-1)/2
//   out_valid / out_ready result handshake
//   out [d*W]             sharing of ina & inb, registered terms only
//
// Parameters: d (shares, default `DEFAULTSHARES), W (lanes),
//   HAVE_INNER (1: include a_i&b_i inner term).
// Optional macro MSKAND_ZEROIZE_EN: bubbles load zero into stage data
//   registers, so out is 0 whenever out_valid is 0.

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_and_hpc2_pipe #(
  parameter int unsigned d          = `DEFAULTSHARES,
  parameter int unsigned W          = 1,
  parameter int unsigned HAVE_INNER = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [d*W-1:0]               ina,
  input  logic [d*W-1:0]               inb,
  input  logic                         rnd_valid,
  output logic                         rnd_ready,
  input  logic [W*(d*(d-1)/2)-1:0]     rnd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [d*W-1:0]               out
);

  localparam int unsigned R  = d * (d - 1) / 2;
  localparam int unsigned RW = W * R;
  // Ordered off-diagonal pairs (i != j) per lane.
  localparam int unsigned P  = d * (d - 1);

`ifdef MSKAND_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  // Offset of the shared random bit r_ij (= r_ji) within a lane.
  function automatic int unsigned ridx(input int unsigned i, input int unsigned j);
    int unsigned lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
  endfunction

  // Packed position of ordered pair (i,j), i != j, in lane k.
  function automatic int unsigned pidx(input int unsigned k, input int unsigned i,
                                       input int unsigned j);
    return k * P + i * (d - 1) + ((j < i) ? j : j - 1);
  endfunction

  logic            v1, v2;
  logic            en1, en2, acc;

  logic [d*W-1:0]  a1, b1;
  logic [RW-1:0]   r1;
  logic [W*P-1:0]  vreg, vreg_d;

  logic [W*P-1:0]  u, w, u_d, w_d;
  logic [d*W-1:0]  ab, ab_d;

  always_comb begin
    en2       = !v2 || out_ready;
    en1       = !v1 || en2;
    acc       = in_valid && rnd_valid && en1 && !rst;
    in_ready  = en1 && rnd_valid && !rst;
    rnd_ready = en1 && in_valid && !rst;
  end

  // Stage-1 terms: v_ij = b_j ^ r_ij, masked before it meets a_i.
  always_comb begin
    vreg_d = '0;
    for (int unsigned k = 0; k < W; k++)
      for (int unsigned i = 0; i < d; i++)
        for (int unsigned j = 0; j < d; j++)
          if (i != j)
            vreg_d[pidx(k, i, j)] = inb[k*d+j] ^ rnd[k*R+ridx(i, j)];
  end

  // Stage-2 product terms; each is registered on its own before the XOR tree.
  always_comb begin
    u_d  = '0;
    w_d  = '0;
    ab_d = '0;
    for (int unsigned k = 0; k < W; k++)
      for (int unsigned i = 0; i < d; i++) begin
        if (HAVE_INNER != 0)
          ab_d[k*d+i] = a1[k*d+i] & b1[k*d+i];
        for (int unsigned j = 0; j < d; j++)
          if (i != j) begin
            u_d[pidx(k, i, j)] = ~a1[k*d+i] & r1[k*R+ridx(i, j)];
            w_d[pidx(k, i, j)] =  a1[k*d+i] & vreg[pidx(k, i, j)];
          end
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      r1   <= '0;
      vreg <= '0;
    end else if (en1) begin
      v1 <= acc;
      if (ZEROIZE && !acc) begin
        a1   <= '0;
        b1   <= '0;
        r1   <= '0;
        vreg <= '0;
      end else begin
        a1   <= ina;
        b1   <= (HAVE_INNER != 0) ? inb : '0;
        r1   <= rnd;
        vreg <= vreg_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      u  <= '0;
      w  <= '0;
      ab <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (ZEROIZE && !v1) begin
        u  <= '0;
        w  <= '0;
        ab <= '0;
      end else begin
        u  <= u_d;
        w  <= w_d;
        ab <= ab_d;
      end
    end
  end

  // Recombination only from stage-2 registers.
  always_comb begin
    out = '0;
    for (int unsigned k = 0; k < W; k++)
      for (int unsigned i = 0; i < d; i++) begin
        out[k*d+i] = ab[k*d+i];
        for (int unsigned j = 0; j < d; j++)
          if (i != j)
            out[k*d+i] = out[k*d+i] ^ u[pidx(k, i, j)] ^ w[pidx(k, i, j)];
      end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_msk_and_hpc2_pipe.sv
// Testbench for msk_and_hpc2_pipe: two instances (with and without the inner
// term) share one stimulus stream; a scoreboard queue holds expected unmasked
// results, and a negedge monitor compares whenever out_valid & out_ready.

module tb_msk_and_hpc2_pipe;

  localparam int unsigned D  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned RR = D * (D - 1) / 2;
  localparam int unsigned RW = W * RR;
  localparam int unsigned NS = D * W;

  logic          clk, rst;
  logic          in_valid, rnd_valid, out_ready;
  logic [NS-1:0] ina, inb;
  logic [RW-1:0] rnd;

  logic          in_ready_f, rnd_ready_f, out_valid_f;
  logic          in_ready_c, rnd_ready_c, out_valid_c;
  logic [NS-1:0] out_f, out_c;

  msk_and_hpc2_pipe #(.d(D), .W(W), .HAVE_INNER(1)) dut_full (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_f), .ina(ina), .inb(inb),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_f), .rnd(rnd),
    .out_valid(out_valid_f), .out_ready(out_ready), .out(out_f)
  );

  msk_and_hpc2_pipe #(.d(D), .W(W), .HAVE_INNER(0)) dut_cross (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_c), .ina(ina), .inb(inb),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_c), .rnd(rnd),
    .out_valid(out_valid_c), .out_ready(out_ready), .out(out_c)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] inner;
    int           acc;
    int           lat;
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  int    pops  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] unmask(input logic [NS-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < D; i++)
        r[k] = r[k] ^ v[k*D+i];
    return r;
  endfunction

  // Monitor: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_ready && (out_valid_f || out_valid_c)) begin
        chk("out_valid_full", {63'd0, out_valid_f}, 64'd1);
        chk("out_valid_cross", {63'd0, out_valid_c}, 64'd1);
        if (q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          item_t it;
          it = q.pop_front();
          pops++;
          chk("product_full", {56'd0, unmask(out_f)}, {56'd0, it.a & it.b});
          chk("product_cross", {56'd0, unmask(out_c)}, {56'd0, (it.a & it.b) ^ it.inner});
          if (it.lat != 0)
            chk("latency", 64'(cyc - it.acc), 64'(it.lat));
        end
      end
`ifdef MSKAND_ZEROIZE_EN
      if (!out_valid_f) chk("bubble_zero_full", {40'd0, out_f}, 64'd0);
      if (!out_valid_c) chk("bubble_zero_cross", {40'd0, out_c}, 64'd0);
`endif
    end
  end

  // One cycle of stimulus: drive just after posedge, decide acceptance at negedge.
  task automatic step(input bit iv, input bit rv, input bit orr,
                      input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    item_t it;
    logic  xa, xb, s;
    @(posedge clk);
    #1;
    in_valid  = iv;
    rnd_valid = rv;
    out_ready = orr;
    for (int k = 0; k < W; k++) begin
      xa = 1'b0;
      xb = 1'b0;
      for (int i = 0; i < D - 1; i++) begin
        s = 1'($urandom_range(0, 1)); ina[k*D+i] = s; xa = xa ^ s;
        s = 1'($urandom_range(0, 1)); inb[k*D+i] = s; xb = xb ^ s;
      end
      ina[k*D+D-1] = a[k] ^ xa;
      inb[k*D+D-1] = b[k] ^ xb;
    end
    rnd = RW'($urandom);
    it.a = a;
    it.b = b;
    it.inner = '0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < D; i++)
        it.inner[k] = it.inner[k] ^ (ina[k*D+i] & inb[k*D+i]);
    it.lat = lat;
    @(negedge clk);
    it.acc = cyc;
    if (iv && rv && in_ready_f) q.push_back(it);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, '0, '0, 0);
  endtask

  logic [NS-1:0] snap;
  int            p0;

  initial begin
    rst = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    ina = '0; inb = '0; rnd = '0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid_f}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_f}, 64'd0);
    chk("rst_rnd_ready", {63'd0, rnd_ready_f}, 64'd0);
    chk("rst_out", {40'd0, out_f}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0; rnd_valid = 1'b0;
    rst = 1'b0;
    idle(2);

    // Single transfer, free flow.
    step(1'b1, 1'b1, 1'b1, 8'h0A, 8'h0C, 2);
    idle(4);

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 8'(i), 8'h0F, 2);
    idle(4);

    // Stall: two accepted, third refused, output held.
    step(1'b1, 1'b1, 1'b0, 8'h35, 8'h5C, 0);
    step(1'b1, 1'b1, 1'b0, 8'hF0, 8'h3C, 0);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 0);
    chk("stall_in_ready", {63'd0, in_ready_f}, 64'd0);
    snap = out_f;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, 0);
      chk("stall_valid", {63'd0, out_valid_f}, 64'd1);
      chk("stall_hold", {40'd0, out_f}, {40'd0, snap});
      chk("stall_value", {56'd0, unmask(out_f)}, {56'd0, 8'h35 & 8'h5C});
    end
    idle(4);
    chk("stall_drained", 64'(q.size()), 64'd0);

    // Randomness withheld.
    p0 = pops;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h77, 8'h99, 0);
      chk("no_rnd_in_ready", {63'd0, in_ready_f}, 64'd0);
    end
    step(1'b1, 1'b1, 1'b1, 8'h77, 8'h99, 2);
    idle(4);
    chk("rnd_one_accept", 64'(pops - p0), 64'd1);

    // Asynchronous reset with two transfers in flight.
    step(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 0);
    step(1'b1, 1'b1, 1'b1, 8'h56, 8'h78, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("async_rst_valid", {63'd0, out_valid_f}, 64'd0);
    chk("async_rst_out", {40'd0, out_f}, 64'd0);
    chk("async_rst_out_cross", {40'd0, out_c}, 64'd0);
    in_valid = 1'b1; rnd_valid = 1'b1;
    #1;
    chk("async_rst_in_ready", {63'd0, in_ready_f}, 64'd0);
    chk("async_rst_rnd_ready", {63'd0, rnd_ready_f}, 64'd0);
    in_valid = 1'b0; rnd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    p0 = pops;
    idle(5);
    chk("post_rst_silent", 64'(pops - p0), 64'd0);

    // Random traffic with random back-pressure.
    for (int n = 0; n < 1000; n++)
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 0);

    // Bounded drain.
    for (int n = 0; n < 50 && q.size() != 0; n++) idle(1);
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
